cmp_stream_monitor: RTL
=======================

Name: cmp_stream_monitor

Overview:
- Downstream consumer of the 2-bit comparator's Eq/Lt/Gt outputs.
- Samples the comparator result when in_valid is high and checks that exactly one flag is set.
- Keeps saturating per-outcome counters and an illegal-code counter.
- Runs a streak FSM that raises alarm after ALARM_LEN consecutive Gt results; feeds the status/debug logic.

Parameters:
- CNT_W, 8, width of each outcome counter and of err_cnt (saturating)
- ALARM_LEN, 4, consecutive valid Gt samples needed to assert alarm; legal range 1 to 2^CNT_W-1

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  eq_in/lt_in/gt_in carry a result this cycle
- eq_in  input  1  comparator Eq
- lt_in  input  1  comparator Lt
- gt_in  input  1  comparator Gt
- clr  input  1  synchronous clear of counters, streak and FSM
- eq_cnt  output  CNT_W  count of legal Eq samples
- lt_cnt  output  CNT_W  count of legal Lt samples
- gt_cnt  output  CNT_W  count of legal Gt samples
- err_cnt  output  CNT_W  count of illegal codes
- code_err  output  1  one-cycle pulse, illegal code sampled on the previous edge
- streak  output  CNT_W  current consecutive-Gt run length
- alarm  output  1  high while the FSM is in ALARM

Behaviour:
- Reset (rst_n=0, async): all counters, streak, code_err and alarm go to 0; FSM goes to IDLE. Outputs are driven from registers only.
- Sampling: a sample is taken on a rising edge with in_valid=1 and clr=0.
- Legal code: {eq_in,lt_in,gt_in} has exactly one bit set (100, 010 or 001). Codes 000, 011, 101, 110 and 111 are illegal.
- Legal sample increments the matching counter by 1. The update is visible one cycle after the sampling edge.
- Counter saturation: each counter holds at 2^CNT_W-1 and never wraps. Saturation of one counter does not affect the others.
- Illegal sample:
  - err_cnt increments (saturating) and code_err=1 for exactly one cycle after the edge.
  - The other counters are unchanged.
  - streak is forced to 0 and the FSM goes to IDLE.
- Back-to-back illegal samples keep code_err high continuously.
- Cycles with in_valid=0 change nothing: streak is held and code_err drops to 0.
- streak:
  - +1 (saturating) on each legal Gt sample.
  - 0 on a legal Eq or Lt sample or an illegal sample.
- FSM states and transitions:
  - IDLE (streak=0): legal Gt goes to RUN, or directly to ALARM when ALARM_LEN=1.
  - RUN (0<streak<ALARM_LEN): legal Gt with streak+1==ALARM_LEN goes to ALARM; other legal Gt stays in RUN; Eq, Lt or illegal goes to IDLE.
  - ALARM: legal Gt stays in ALARM (streak keeps counting, saturating); Eq, Lt or illegal goes to IDLE.
- alarm = (state==ALARM). It is registered, rising on the same edge that samples the ALARM_LEN-th consecutive Gt.
- clr=1 on an edge:
  - All counters, streak and code_err go to 0; FSM goes to IDLE.
  - clr has priority over a simultaneous in_valid, and that sample is discarded.
  - A clr held for multiple cycles keeps everything at 0.
- Reset mid-streak or mid-alarm: asynchronous clear and immediate IDLE. The first sample after release starts from an empty state.

Optional Feature:
- Macro: CMP_MON_STICKY_ERR_EN.
- When defined:
  - code_err becomes a sticky flag: set by any illegal sample and held until clr or reset.
  - err_cnt behaviour is unchanged.
- When undefined: code_err is the one-cycle pulse described above.

Test Plan:
- Reset then 3 valid Eq (100), 2 valid Lt (010) → eq_cnt=3, lt_cnt=2, gt_cnt=0, err_cnt=0, alarm=0, streak=0.
- ALARM_LEN=4: sequence Gt,Gt,(in_valid=0 for 2 cycles),Gt,Gt → streak=4 and alarm=1 after the 4th Gt edge. A following Lt → alarm=0 and streak=0 on the next edge.
- Illegal 011 sample mid-streak (streak=2) → code_err=1 for one cycle, err_cnt=1, streak=0, gt_cnt unchanged. Repeat with 000 and 111 → err_cnt=3. With CMP_MON_STICKY_ERR_EN, code_err stays 1 until clr.
- CNT_W=3: 9 valid Gt samples → gt_cnt holds at 7 and does not wrap; alarm stays 1 while Gt continues.
- clr asserted in the same cycle as in_valid=1 with Gt while alarm=1 → all counters 0, streak 0, alarm 0; the Gt sample is not counted.
- rst_n pulsed low asynchronously between edges while alarm=1 and gt_cnt=5 → outputs 0 immediately; after release, one Gt → gt_cnt=1, streak=1, alarm=0.

Source files
------------

// File: rtl/cmp_stream_monitor.sv
// Monitors the Eq/Lt/Gt stream of a 2-bit comparator: outcome counters, illegal-code detection
// and a consecutive-Gt alarm FSM. Define CMP_MON_STICKY_ERR_EN to make code_err sticky.
module cmp_stream_monitor #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned ALARM_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             eq_in,
    input  logic             lt_in,
    input  logic             gt_in,
    input  logic             clr,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             code_err,
    output logic [CNT_W-1:0] streak,
    output logic             alarm
);

    typedef enum logic [1:0] {StIdle, StRun, StAlarm} state_e;

    localparam logic [CNT_W-1:0] AlarmLenW = CNT_W'(ALARM_LEN);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] eq_q, eq_d, lt_q, lt_d, gt_q, gt_d, err_q, err_d;
    logic [CNT_W-1:0] streak_q, streak_d, streak_inc;
    logic             code_err_q, code_err_d;
    logic             legal;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign legal      = (eq_in ^ lt_in ^ gt_in) & ~(eq_in & lt_in & gt_in);
    assign streak_inc = sat_inc(streak_q);

    always_comb begin
        state_d  = state_q;
        eq_d     = eq_q;
        lt_d     = lt_q;
        gt_d     = gt_q;
        err_d    = err_q;
        streak_d = streak_q;
`ifdef CMP_MON_STICKY_ERR_EN
        code_err_d = code_err_q;
`else
        code_err_d = 1'b0;
`endif
        if (clr) begin
            // clr wins over a coincident sample, which is dropped
            state_d    = StIdle;
            eq_d       = '0;
            lt_d       = '0;
            gt_d       = '0;
            err_d      = '0;
            streak_d   = '0;
            code_err_d = 1'b0;
        end else if (in_valid) begin
            if (!legal) begin
                err_d      = sat_inc(err_q);
                code_err_d = 1'b1;
                streak_d   = '0;
                state_d    = StIdle;
            end else if (eq_in) begin
                eq_d     = sat_inc(eq_q);
                streak_d = '0;
                state_d  = StIdle;
            end else if (lt_in) begin
                lt_d     = sat_inc(lt_q);
                streak_d = '0;
                state_d  = StIdle;
            end else begin
                gt_d     = sat_inc(gt_q);
                streak_d = streak_inc;
                unique case (state_q)
                    StIdle:  state_d = (ALARM_LEN == 1) ? StAlarm : StRun;
                    StRun:   state_d = (streak_inc == AlarmLenW) ? StAlarm : StRun;
                    StAlarm: state_d = StAlarm;
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            eq_q       <= '0;
            lt_q       <= '0;
            gt_q       <= '0;
            err_q      <= '0;
            streak_q   <= '0;
            code_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            eq_q       <= eq_d;
            lt_q       <= lt_d;
            gt_q       <= gt_d;
            err_q      <= err_d;
            streak_q   <= streak_d;
            code_err_q <= code_err_d;
        end
    end

    assign eq_cnt   = eq_q;
    assign lt_cnt   = lt_q;
    assign gt_cnt   = gt_q;
    assign err_cnt  = err_q;
    assign streak   = streak_q;
    assign code_err = code_err_q;
    assign alarm    = (state_q == StAlarm);

endmodule
